hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Issue-side RAW/WAW/writeback-collision tracker for one register file (integer or FP) of the rv32imf core. It records every issued writer's destination register and fixed latency in a timing wheel, and drives `no_dependency`, `no_collision` and `rd_not_busy`, the stall qualifiers consumed by the forwarding value-capture logic. It also drives the writeback slot schedule, `wb_valid`/`wb_rd`, toward the register file.

## Interface
- `MAX_LAT`, 8, maximum issue-to-writeback latency in cycles (2..15).
- `FP_type`, 0, 0: register 0 is hardwired (never busy, never a dependency); 1: register 0 is an ordinary FP register.
- `clk  in  1  clock`
- `reset_n  in  1  asynchronous active-low reset`
- `flush  in  1  synchronous clear of all tracked state`
- `issue_valid  in  1  instruction in decode requests issue`
- `issue_rd  in  5  destination register`
- `issue_rd_we  in  1  instruction writes issue_rd`
- `issue_lat  in  4  cycles from issue to writeback`
- `issue_rs1 / issue_rs2 / issue_rs3  in  5 each  source registers`
- `issue_rs1_used / issue_rs2_used / issue_rs3_used  in  1 each  source is read`
- `issue_fire  out  1  issue accepted this cycle`
- `no_dependency  out  1  no RAW hazard on any used source`
- `no_collision  out  1  no WAW hazard, no writeback-slot conflict, latency legal`
- `rd_not_busy  out  1  issue_rd has no outstanding writer`
- `lat_err  out  1  issue_valid with issue_lat outside 1..MAX_LAT`
- `wb_valid  out  1  a tracked writer retires this cycle`
- `wb_rd  out  5  register retiring this cycle`
- `busy_vec  out  32  per-register outstanding-writer bits`
- `stall_cnt  out  16  stall counter (present only with macro)`

## Operation
- State:
  - wheel of MAX_LAT slots `{valid, rd}`; slot 0 is the current writeback.
  - `busy[31:0]`.
- Retire: `retiring(r) = slot[0].valid & slot[0].rd == r`. `wb_valid = slot[0].valid`, `wb_rd = slot[0].rd`.
- RAW: source i is hazardous if `used_i & busy[rs_i] & !retiring(rs_i) & !(FP_type==0 & rs_i==0)`. A retiring register is forwardable from WB, so it is not a hazard. `no_dependency` = no hazardous source.
- WAW: `issue_rd_we & busy[issue_rd] & !retiring(issue_rd)`, with rd 0 excluded when FP_type=0.
- Slot conflict: `issue_rd_we & issue_lat < MAX_LAT & slot[issue_lat].valid`.
- `no_collision = !(WAW | slot conflict | lat_err)`.
- `lat_err = issue_valid & (issue_lat == 0 | issue_lat > MAX_LAT)`.
- `rd_not_busy = !busy[issue_rd] | retiring(issue_rd)`.
- `issue_fire = issue_valid & no_dependency & no_collision & !flush`.
- Clock edge, in priority order:
  - flush: clear all slots and busy.
  - Otherwise shift `slot[k] <= slot[k+1]` and `slot[MAX_LAT-1] <= 0`.
  - Clear `busy[slot[0].rd]` if `slot[0].valid`.
  - If `issue_fire & issue_rd_we` and rd is not hardwired 0: `slot[issue_lat-1] <= {1, issue_rd}` and `busy[issue_rd] <= 1`. A set overrides a clear of the same bit.
- Writers with `issue_rd_we=0`, or to hardwired x0, occupy no slot.
- Invariant: at most one valid slot per rd, and at most one writer per slot.

## Timing
- Issue accepted at cycle t with lat L: `wb_valid=1`, `wb_rd=rd` during cycle t+L. busy is set from t+1 through t+L; it reads 0 from t+L+1.
- A consumer of rd issues no earlier than cycle t+L, through the WB-forward exemption.
- All hazard outputs are combinational from the inputs and current state; zero latency.
- Reset values:
  - slots empty; `busy_vec=0`, `wb_valid=0`, `wb_rd=0`.
  - `no_dependency=1`, `rd_not_busy=1`.
  - `no_collision=1` and `lat_err=0` for legal inputs.
  - `issue_fire=issue_valid`; `stall_cnt=0`.
- Reset mid-operation: all in-flight writers are dropped and none retire.
- Flush: in-flight writers dropped from the next cycle; the current `slot[0]` still shows `wb_valid` in the flush cycle.
- lat = MAX_LAT: no slot conflict possible, since the top slot is always empty after shift.

## Configuration
- `HAZARD_SCOREBOARD_STATS_EN`:
  - Defined: `stall_cnt` increments by 1 each cycle with `issue_valid & !issue_fire`, saturates at 0xFFFF, and is cleared by reset only.
  - Undefined: the port is absent and there is no counter logic.

## Test plan
- Issue rd=5, lat=3 at cycle 0, then request rs1=5 every cycle:
  - `no_dependency=0` in cycles 1–2.
  - Cycle 3: `wb_valid=1`, `wb_rd=5`, `no_dependency=1`, `issue_fire=1`.
  - `busy_vec[5]=0` in cycle 4.
- Issue rd=4, lat=4 at cycle 0, then rd=6, lat=3 at cycle 1: `no_collision=0` (slot conflict). Retrying lat=3 at cycle 2 fires, and rd=6 retires at cycle 5.
- Issue rd=7, lat=5, then immediately rd=7, lat=2: WAW gives `no_collision=0`, `rd_not_busy=0`. The second issue fires in the cycle `wb_rd=7`.
- FP_type=0: issue rd=0, lat=2 gives no slot and `busy_vec=0`; rs1=0 never stalls. With FP_type=1, register 0 behaves like any other.
- issue_lat=0 or 9 with MAX_LAT=8: `lat_err=1`, `no_collision=0`, `issue_fire=0`.
- Three writers in flight:
  - Assert flush: `busy_vec=0` next cycle and no further `wb_valid`.
  - Repeat with reset_n low: same result asynchronously.
  - With the macro defined: 4 stalled cycles give `stall_cnt=4`.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Issue-side RAW / WAW / writeback-collision tracker for one register file.
// Every accepted writer is placed in a timing wheel at the slot matching its
// latency. Slot 0 is the writeback happening this cycle. A per-register busy
// vector answers RAW/WAW queries with zero latency.
//
// Optional feature: define HAZARD_SCOREBOARD_STATS_EN to add the stall_cnt
// output. It is a saturating count of cycles with a requested but unaccepted
// issue, and is cleared by reset only.
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   flush                        synchronous clear of all tracked writers
//   issue_valid/rd/rd_we/lat     issuing instruction and its writer info
//   issue_rs1..3 (+ _used)       source registers read by the instruction
//   issue_fire                   instruction accepted this cycle
//   no_dependency                no RAW hazard on any used source
//   no_collision                 no WAW, no writeback-slot conflict, legal lat
//   rd_not_busy                  issue_rd has no outstanding writer
//   lat_err                      issue_valid with latency outside 1..MAX_LAT
//   wb_valid, wb_rd              writer retiring this cycle
//   busy_vec                     per-register outstanding-writer bits
//   stall_cnt                    stall counter (macro only)
module hazard_scoreboard #(
    parameter int MAX_LAT = 8,
    parameter int FP_type = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_we,
    input  logic [3:0]  issue_lat,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rs3,
    input  logic        issue_rs1_used,
    input  logic        issue_rs2_used,
    input  logic        issue_rs3_used,
    output logic        issue_fire,
    output logic        no_dependency,
    output logic        no_collision,
    output logic        rd_not_busy,
    output logic        lat_err,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
`ifdef HAZARD_SCOREBOARD_STATS_EN
    output logic [15:0] stall_cnt,
`endif
    output logic [31:0] busy_vec
);

    localparam logic [3:0] LAT_MAX4 = 4'(MAX_LAT);
    // Register 0 is hardwired zero for the integer file.
    localparam bit         HW_ZERO  = (FP_type == 0);

    logic [MAX_LAT-1:0]       r_slot_v;
    logic [MAX_LAT-1:0][4:0]  r_slot_rd;
    logic [31:0]              r_busy;

    logic        w_haz1, w_haz2, w_haz3;
    logic        w_waw, w_slot_conf, w_rd_hw, w_rd_retiring, w_alloc;
    logic [31:0] w_busy_nxt;

    assign wb_valid = r_slot_v[0];
    assign wb_rd    = r_slot_rd[0];
    assign busy_vec = r_busy;

    // A register retiring this cycle is forwardable from WB, so it never stalls.
    assign w_haz1 = issue_rs1_used & r_busy[issue_rs1]
                  & ~(wb_valid & (wb_rd == issue_rs1)) & ~(HW_ZERO & (issue_rs1 == 5'd0));
    assign w_haz2 = issue_rs2_used & r_busy[issue_rs2]
                  & ~(wb_valid & (wb_rd == issue_rs2)) & ~(HW_ZERO & (issue_rs2 == 5'd0));
    assign w_haz3 = issue_rs3_used & r_busy[issue_rs3]
                  & ~(wb_valid & (wb_rd == issue_rs3)) & ~(HW_ZERO & (issue_rs3 == 5'd0));

    assign w_rd_hw       = HW_ZERO & (issue_rd == 5'd0);
    assign w_rd_retiring = wb_valid & (wb_rd == issue_rd);
    assign w_waw         = issue_rd_we & r_busy[issue_rd] & ~w_rd_retiring & ~w_rd_hw;

    // Compare against slot index rather than indexing by issue_lat, so an
    // out-of-range latency can never address past the wheel. lat == MAX_LAT
    // lands in the top slot, which is always empty after the shift.
    always_comb begin
        w_slot_conf = 1'b0;
        for (int k = 1; k < MAX_LAT; k++) begin
            if (issue_lat == 4'(k) && r_slot_v[k]) w_slot_conf = 1'b1;
        end
        w_slot_conf = w_slot_conf & issue_rd_we;
    end

    assign lat_err       = issue_valid & ((issue_lat == 4'd0) | (issue_lat > LAT_MAX4));
    assign no_dependency = ~(w_haz1 | w_haz2 | w_haz3);
    assign no_collision  = ~(w_waw | w_slot_conf | lat_err);
    assign rd_not_busy   = ~r_busy[issue_rd] | w_rd_retiring;
    assign issue_fire    = issue_valid & no_dependency & no_collision & ~flush;
    assign w_alloc       = issue_fire & issue_rd_we & ~w_rd_hw;

    // The set is applied after the clear, so a new writer to the retiring register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_slot_v[0]) w_busy_nxt[r_slot_rd[0]] = 1'b0;
        if (w_alloc)     w_busy_nxt[issue_rd]     = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_v  <= '0;
            r_slot_rd <= '0;
            r_busy    <= '0;
        end else if (flush) begin
            r_slot_v  <= '0;
            r_slot_rd <= '0;
            r_busy    <= '0;
        end else begin
            for (int k = 0; k < MAX_LAT - 1; k++) begin
                r_slot_v[k]  <= r_slot_v[k+1];
                r_slot_rd[k] <= r_slot_rd[k+1];
            end
            r_slot_v[MAX_LAT-1]  <= 1'b0;
            r_slot_rd[MAX_LAT-1] <= 5'd0;
            if (w_alloc) begin
                for (int k = 0; k < MAX_LAT; k++) begin
                    if (issue_lat == 4'(k + 1)) begin
                        r_slot_v[k]  <= 1'b1;
                        r_slot_rd[k] <= issue_rd;
                    end
                end
            end
            r_busy <= w_busy_nxt;
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [15:0] r_stall_cnt;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_stall_cnt <= 16'd0;
        else if (issue_valid && !issue_fire && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: an integer instance (FP_type=0) and an
// FP instance (FP_type=1) driven by the same stimulus.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = 5'd0;
    logic        issue_rd_we = 1'b0;
    logic [3:0]  issue_lat = 4'd1;
    logic [4:0]  issue_rs1 = 5'd0, issue_rs2 = 5'd0, issue_rs3 = 5'd0;
    logic        issue_rs1_used = 1'b0, issue_rs2_used = 1'b0, issue_rs3_used = 1'b0;

    logic        fire, nd, nc, rnb, le, wbv;
    logic [4:0]  wbr;
    logic [31:0] busy;
    logic        f_fire, f_nd, f_nc, f_rnb, f_le, f_wbv;
    logic [4:0]  f_wbr;
    logic [31:0] f_busy;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [15:0] stall, f_stall;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.MAX_LAT(8), .FP_type(0)) u_int (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .issue_lat(issue_lat), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs3(issue_rs3), .issue_rs1_used(issue_rs1_used),
        .issue_rs2_used(issue_rs2_used), .issue_rs3_used(issue_rs3_used),
        .issue_fire(fire), .no_dependency(nd), .no_collision(nc),
        .rd_not_busy(rnb), .lat_err(le), .wb_valid(wbv), .wb_rd(wbr),
`ifdef HAZARD_SCOREBOARD_STATS_EN
        .stall_cnt(stall),
`endif
        .busy_vec(busy)
    );

    hazard_scoreboard #(.MAX_LAT(8), .FP_type(1)) u_fp (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .issue_lat(issue_lat), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs3(issue_rs3), .issue_rs1_used(issue_rs1_used),
        .issue_rs2_used(issue_rs2_used), .issue_rs3_used(issue_rs3_used),
        .issue_fire(f_fire), .no_dependency(f_nd), .no_collision(f_nc),
        .rd_not_busy(f_rnb), .lat_err(f_le), .wb_valid(f_wbv), .wb_rd(f_wbr),
`ifdef HAZARD_SCOREBOARD_STATS_EN
        .stall_cnt(f_stall),
`endif
        .busy_vec(f_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one issue request; rs is applied to the sources selected by used.
    task automatic iss(input logic v, input logic [4:0] rd, input logic we,
                       input logic [3:0] lat, input logic [4:0] rs, input logic [2:0] used);
        issue_valid    = v;
        issue_rd       = rd;
        issue_rd_we    = we;
        issue_lat      = lat;
        issue_rs1      = rs;
        issue_rs2      = rs;
        issue_rs3      = rs;
        issue_rs1_used = used[0];
        issue_rs2_used = used[1];
        issue_rs3_used = used[2];
        #1;
    endtask

    task automatic idle();
        iss(1'b0, 5'd0, 1'b0, 4'd1, 5'd0, 3'b000);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #12;
        idle();
        chk("rst_busy", busy, 32'h0);
        chk("rst_wbv", {31'b0, wbv}, 32'd0);
        chk("rst_wbr", {27'b0, wbr}, 32'd0);
        chk("rst_nd", {31'b0, nd}, 32'd1);
        chk("rst_rnb", {31'b0, rnb}, 32'd1);
        chk("rst_nc", {31'b0, nc}, 32'd1);
        chk("rst_le", {31'b0, le}, 32'd0);
        chk("rst_fire_idle", {31'b0, fire}, 32'd0);
        iss(1'b1, 5'd5, 1'b1, 4'd3, 5'd0, 3'b000);
        chk("rst_fire_req", {31'b0, fire}, 32'd1);
        idle();
        reset_n = 1'b1;

        // RAW on rd5 lat3, consumer released through WB forward at cycle 3
        cyc(); iss(1'b1, 5'd5, 1'b1, 4'd3, 5'd0, 3'b000);
        chk("raw_c0_fire", {31'b0, fire}, 32'd1);
        cyc(); iss(1'b1, 5'd10, 1'b0, 4'd1, 5'd5, 3'b001);
        chk("raw_c1_nd", {31'b0, nd}, 32'd0);
        chk("raw_c1_fire", {31'b0, fire}, 32'd0);
        chk("raw_c1_busy", busy, 32'h0000_0020);
        cyc(); iss(1'b1, 5'd10, 1'b0, 4'd1, 5'd5, 3'b100);
        chk("raw_c2_nd_rs3", {31'b0, nd}, 32'd0);
        cyc(); iss(1'b1, 5'd10, 1'b0, 4'd1, 5'd5, 3'b001);
        chk("raw_c3_wbv", {31'b0, wbv}, 32'd1);
        chk("raw_c3_wbr", {27'b0, wbr}, 32'd5);
        chk("raw_c3_nd", {31'b0, nd}, 32'd1);
        chk("raw_c3_fire", {31'b0, fire}, 32'd1);
        cyc(); idle();
        chk("raw_c4_busy", busy, 32'h0);

        // writeback slot conflict
        cyc(); iss(1'b1, 5'd4, 1'b1, 4'd4, 5'd0, 3'b000);
        chk("slot_c0_fire", {31'b0, fire}, 32'd1);
        cyc(); iss(1'b1, 5'd6, 1'b1, 4'd3, 5'd0, 3'b000);
        chk("slot_c1_nc", {31'b0, nc}, 32'd0);
        chk("slot_c1_fire", {31'b0, fire}, 32'd0);
        cyc(); iss(1'b1, 5'd6, 1'b1, 4'd3, 5'd0, 3'b000);
        chk("slot_c2_fire", {31'b0, fire}, 32'd1);
        cyc(); idle();
        cyc();
        chk("slot_c4_wbr", {26'b0, wbv, wbr}, 32'h24);
        cyc();
        chk("slot_c5_wbr", {26'b0, wbv, wbr}, 32'h26);
        cyc();
        chk("slot_c6_wbv", {31'b0, wbv}, 32'd0);
        chk("slot_c6_busy", busy, 32'h0);

        // WAW on rd7
        cyc(); iss(1'b1, 5'd7, 1'b1, 4'd5, 5'd0, 3'b000);
        chk("waw_c0_fire", {31'b0, fire}, 32'd1);
        cyc(); iss(1'b1, 5'd7, 1'b1, 4'd2, 5'd0, 3'b000);
        chk("waw_c1_nc", {31'b0, nc}, 32'd0);
        chk("waw_c1_rnb", {31'b0, rnb}, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) begin
                cyc(); iss(1'b1, 5'd7, 1'b1, 4'd2, 5'd0, 3'b000);
            end
            chk($sformatf("waw_c%0d_fire", c), {31'b0, fire}, 32'd0);
        end
        cyc(); iss(1'b1, 5'd7, 1'b1, 4'd2, 5'd0, 3'b000);
        chk("waw_c5_wb", {26'b0, wbv, wbr}, 32'h27);
        chk("waw_c5_rnb", {31'b0, rnb}, 32'd1);
        chk("waw_c5_fire", {31'b0, fire}, 32'd1);
        cyc(); idle();
        chk("waw_c6_busy", busy, 32'h0000_0080);
        cyc();
        chk("waw_c7_wb", {26'b0, wbv, wbr}, 32'h27);
        cyc();
        chk("waw_c8_busy", busy, 32'h0);

        // register 0: hardwired in the integer instance, ordinary in FP
        cyc(); iss(1'b1, 5'd0, 1'b1, 4'd2, 5'd0, 3'b000);
        chk("r0_c0_fire", {31'b0, fire}, 32'd1);
        chk("r0_c0_ffire", {31'b0, f_fire}, 32'd1);
        cyc(); iss(1'b1, 5'd11, 1'b0, 4'd1, 5'd0, 3'b001);
        chk("r0_c1_busy", busy, 32'h0);
        chk("r0_c1_nd", {31'b0, nd}, 32'd1);
        chk("r0_c1_fbusy", f_busy, 32'h1);
        chk("r0_c1_fnd", {31'b0, f_nd}, 32'd0);
        cyc(); idle();
        chk("r0_c2_wbv", {31'b0, wbv}, 32'd0);
        chk("r0_c2_fwb", {26'b0, f_wbv, f_wbr}, 32'h20);
        cyc();
        chk("r0_c3_fbusy", f_busy, 32'h0);

        // latency legality
        cyc(); iss(1'b1, 5'd12, 1'b1, 4'd0, 5'd0, 3'b000);
        chk("lat0_le", {31'b0, le}, 32'd1);
        chk("lat0_nc", {31'b0, nc}, 32'd0);
        chk("lat0_fire", {31'b0, fire}, 32'd0);
        iss(1'b1, 5'd12, 1'b1, 4'd9, 5'd0, 3'b000);
        chk("lat9_le", {31'b0, le}, 32'd1);
        chk("lat9_nc", {31'b0, nc}, 32'd0);
        chk("lat9_fire", {31'b0, fire}, 32'd0);
        iss(1'b1, 5'd12, 1'b0, 4'd8, 5'd0, 3'b000);
        chk("lat8_le", {31'b0, le}, 32'd0);
        chk("lat8_fire", {31'b0, fire}, 32'd1);
        cyc(); idle();

        // flush with three writers in flight
        cyc(); iss(1'b1, 5'd1, 1'b1, 4'd3, 5'd0, 3'b000);
        chk("fl_i1", {31'b0, fire}, 32'd1);
        cyc(); iss(1'b1, 5'd2, 1'b1, 4'd4, 5'd0, 3'b000);
        chk("fl_i2", {31'b0, fire}, 32'd1);
        cyc(); iss(1'b1, 5'd3, 1'b1, 4'd5, 5'd0, 3'b000);
        chk("fl_i3", {31'b0, fire}, 32'd1);
        cyc(); iss(1'b1, 5'd9, 1'b1, 4'd1, 5'd0, 3'b000);
        flush = 1'b1;
        #1;
        chk("fl_c3_busy", busy, 32'h0000_000E);
        chk("fl_c3_wb", {26'b0, wbv, wbr}, 32'h21);
        chk("fl_c3_fire", {31'b0, fire}, 32'd0);
        cyc(); flush = 1'b0; idle();
        chk("fl_c4_busy", busy, 32'h0);
        for (int c = 4; c <= 8; c++) begin
            if (c > 4) cyc();
            chk($sformatf("fl_c%0d_wbv", c), {31'b0, wbv}, 32'd0);
        end

        // asynchronous reset with three writers in flight
        cyc(); iss(1'b1, 5'd1, 1'b1, 4'd3, 5'd0, 3'b000);
        cyc(); iss(1'b1, 5'd2, 1'b1, 4'd4, 5'd0, 3'b000);
        cyc(); iss(1'b1, 5'd3, 1'b1, 4'd5, 5'd0, 3'b000);
        cyc(); idle();
        chk("rs_c3_busy", busy, 32'h0000_000E);
        reset_n = 1'b0;
        #1;
        chk("rs_async_busy", busy, 32'h0);
        chk("rs_async_wbv", {31'b0, wbv}, 32'd0);
        chk("rs_async_fbusy", f_busy, 32'h0);
        #2;
        reset_n = 1'b1;
        for (int c = 4; c <= 9; c++) begin
            cyc();
            chk($sformatf("rs_c%0d_wbv", c), {31'b0, wbv}, 32'd0);
        end
        chk("rs_end_busy", busy, 32'h0);

`ifdef HAZARD_SCOREBOARD_STATS_EN
        chk("stall_zero", {16'b0, stall}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            cyc(); iss(1'b1, 5'd3, 1'b1, 4'd0, 5'd0, 3'b000);
        end
        cyc(); idle();
        chk("stall_four", {16'b0, stall}, 32'd4);
        cyc();
        chk("stall_hold", {16'b0, stall}, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
